instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the core fetch stage (byte-addressed PC in, 32-bit instruction out) and the instruction port of unified main memory.
- On a hit it returns the instruction combinationally with no stall.
- On a miss it asserts stall_cpu and refills the whole line word by word over a request/ready handshake, then serves the fetch.

---
 rtl/instr_cache_pkg.sv | 13 +
 rtl/instr_cache_refill_fsm.sv | 97 +++++++++
 rtl/instr_cache.sv | 92 +++++++++
 tb/tb_instr_cache.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache and its refill engine.
package instr_cache_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } refill_state_e;

endpackage

// File: rtl/instr_cache_refill_fsm.sv
// Line refill engine: walks one cache line word by word over the memory
// request/ready handshake and reports each word write to the cache arrays.
module instr_cache_refill_fsm
    import instr_cache_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start_i,
    input  logic [XLEN-$clog2(LINE_WORDS)-3:0]   line_addr_i,
    input  logic                                 mem_ready_i,
    output logic                                 idle_o,
    output logic                                 fill_we_o,
    output logic                                 fill_last_o,
    output logic [$clog2(LINE_WORDS)-1:0]        word_cnt_o,
    output logic [XLEN-$clog2(LINE_WORDS)-3:0]   line_addr_o,
    output logic [XLEN-1:0]                      mem_addr_o,
    output logic                                 mem_req_o
);
    localparam int OFF = $clog2(LINE_WORDS);
    localparam int LW  = XLEN - OFF - 2;
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    refill_state_e   state_q, state_d;
    logic [OFF-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]   line_q, line_d;
    logic            req_prev_q;
    logic [XLEN-1:0] addr_prev_q;
    logic [XLEN-1:0] word_addr;
    logic            ready_ok;

    assign word_addr = {line_q, cnt_q, 2'b00};
    // A ready left over from the previous word is ignored until the memory has seen this address for a cycle.
    assign ready_ok  = mem_ready_i && req_prev_q && (addr_prev_q == word_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_prev_q  <= 1'b0;
            addr_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_prev_q  <= mem_req_o;
            addr_prev_q <= mem_addr_o;
        end
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        fill_we_o   = 1'b0;
        fill_last_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    line_d  = line_addr_i;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = word_addr;
                if (ready_ok) begin
                    fill_we_o = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_last_o = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                mem_addr_o = word_addr;
                cnt_d      = cnt_q + 1'b1;
                state_d    = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle_o      = (state_q == ST_IDLE);
    assign word_cnt_o  = cnt_q;
    assign line_addr_o = line_q;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path to the
// fetch stage, stall plus whole-line refill from main memory on a miss.
module instr_cache
    import instr_cache_pkg::XLEN;
#(
    parameter int              NUM_LINES  = 64,
    parameter int              LINE_WORDS = 4,
    parameter logic [XLEN-1:0] NOP_INSTR  = instr_cache_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] program_counter_address,
    output logic [XLEN-1:0] instruction,
    output logic            stall_cpu,
    output logic [XLEN-1:0] instruction_memory_address,
    output logic            instruction_memory_request,
    input  logic [XLEN-1:0] instruction_memory_read_data,
    input  logic            instruction_memory_ready
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - OFF - IDX - 2;

    logic [OFF-1:0]        pc_off;
    logic [IDX-1:0]        pc_idx, fill_idx;
    logic [TAG_W-1:0]      pc_tag, fill_tag;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [XLEN-1:0]       data_q [NUM_LINES][LINE_WORDS];
    logic                  fsm_idle, fill_we, fill_last, line_hit, hit;
    logic [OFF-1:0]        fill_cnt;
    logic [XLEN-OFF-3:0]   fill_line;
    logic                  pc_unused;

    assign pc_off    = program_counter_address[OFF+1:2];
    assign pc_idx    = program_counter_address[OFF+IDX+1:OFF+2];
    assign pc_tag    = program_counter_address[XLEN-1:OFF+IDX+2];
    assign pc_unused = ^program_counter_address[1:0];
    assign fill_idx  = fill_line[IDX-1:0];
    assign fill_tag  = fill_line[XLEN-OFF-3:IDX];

    assign line_hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit         = line_hit && fsm_idle;
    assign stall_cpu   = !hit;
    assign instruction = hit ? data_q[pc_idx][pc_off] : NOP_INSTR;

    instr_cache_refill_fsm #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (!line_hit),
        .line_addr_i (program_counter_address[XLEN-1:OFF+2]),
        .mem_ready_i (instruction_memory_ready),
        .idle_o      (fsm_idle),
        .fill_we_o   (fill_we),
        .fill_last_o (fill_last),
        .word_cnt_o  (fill_cnt),
        .line_addr_o (fill_line),
        .mem_addr_o  (instruction_memory_address),
        .mem_req_o   (instruction_memory_request)
    );

    // The line being refilled is invalidated up front so a partially written line can never hit.
    always_comb begin
        valid_d = valid_q;
        if (fsm_idle && !line_hit) begin
            valid_d[pc_idx] = 1'b0;
        end
        if (fill_last) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx][fill_cnt] <= instruction_memory_read_data;
        end
        if (fill_last) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: directed fetches against a latency memory model.
module tb_instr_cache;
    localparam int          LAT = 3;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_r = '0;
    logic [31:0] instr;
    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int issued_cnt = 0, done_cnt = 0, req_seen = 0, tmo_cnt = 0, tmo_seen = 0;
    int n_cmp = 0, n_bad = 0;
    bit rst_chk = 0, end_chk = 0, end_done = 0, stale_mode = 0;
    int lat_cnt = 0;
    logic [31:0] last_addr = '1;

    instr_cache dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .program_counter_address      (pc_r),
        .instruction                  (instr),
        .stall_cpu                    (stall),
        .instruction_memory_address   (mem_addr),
        .instruction_memory_request   (mem_req),
        .instruction_memory_read_data (mem_rdata),
        .instruction_memory_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h000: mem_word = 32'h00500093;
            32'h004: mem_word = 32'h00A00113;
            32'h008: mem_word = 32'h002081B3;
            32'h00C: mem_word = 32'h00000013;
            32'h400: mem_word = 32'h00100513;
            32'h404: mem_word = 32'h00200593;
            32'h408: mem_word = 32'h00B50633;
            32'h40C: mem_word = 32'h00C02023;
            default: mem_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Memory: ready LAT edges after a new address; in stale mode ready/data survive a dropped request.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
            last_addr <= '1;
        end else if (mem_req) begin
            if (mem_addr != last_addr) begin
                last_addr <= mem_addr;
                lat_cnt   <= 1;
                mem_ready <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt + 1;
                if (lat_cnt + 1 >= LAT) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= mem_word(mem_addr);
                end
            end
        end else if (!stale_mode) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
            last_addr <= '1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sole owner of the comparison counters.
    initial begin
        bit          req_last = 0;
        logic [31:0] addr_last = '0;
        int          low_run = 0;
        forever begin
            @(negedge clk);
            if (mem_req && (!req_last || mem_addr != addr_last)) begin
                req_seen++;
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_request: got %h expected none at %0t", mem_addr, $time);
                end else begin
                    check("req_addr", mem_addr, exp_addr_q.pop_front());
                end
                if (mem_addr[3:0] != 4'h0) check("req_gap_cycles", 32'(low_run), 32'd1);
            end
            low_run   = mem_req ? 0 : low_run + 1;
            req_last  = mem_req;
            addr_last = mem_addr;
            if (stall) begin
                check("nop_while_stalled", instr, NOP);
            end else if (done_cnt < issued_cnt) begin
                check("fetch_instr", instr, exp_q.pop_front());
                done_cnt++;
            end
            if (rst_chk) begin
                check("reset_stall", 32'(stall), 32'd1);
                check("reset_request", 32'(mem_req), 32'd0);
                check("reset_address", mem_addr, 32'd0);
            end
            while (tmo_seen < tmo_cnt) begin
                tmo_seen++;
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: got no response expected one within bound (#%0d)", tmo_seen);
            end
            if (end_chk && !end_done) begin
                end_done = 1;
                check("fetches_left", 32'(exp_q.size()), 32'd0);
                check("requests_left", 32'(exp_addr_q.size()), 32'd0);
            end
        end
    end

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt < issued_cnt && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < issued_cnt) tmo_cnt++;
    endtask

    task automatic wait_req(input int target, input int bound);
        int n = 0;
        while (req_seen < target && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_seen < target) tmo_cnt++;
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int w = 0; w < 4; w++) exp_addr_q.push_back({a[31:4], 4'h0} + 32'(4 * w));
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] e, input bit refill, input int bound);
        @(posedge clk);
        #1;
        pc_r = a;
        if (refill) push_line(a);
        exp_q.push_back(e);
        issued_cnt++;
        wait_done(bound);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1 rst_chk = 1;
        @(negedge clk);
        #1 rst_chk = 0;
        rst_n = 1;

        // Cold miss on line 0, then same-line hits.
        fetch(32'h0, 32'h00500093, 1, 200);
        fetch(32'h4, 32'h00A00113, 0, 1);
        fetch(32'h8, 32'h002081B3, 0, 1);
        fetch(32'hC, 32'h00000013, 0, 1);

        // Conflict misses on index 0.
        fetch(32'h400, 32'h00100513, 1, 200);
        fetch(32'h40C, 32'h00C02023, 0, 1);
        fetch(32'h0,   32'h00500093, 1, 200);
        fetch(32'h400, 32'h00100513, 1, 200);

        // PC moves to 0x10 while line 0 is refilling.
        @(posedge clk);
        #1 pc_r = 32'h0;
        push_line(32'h0);
        push_line(32'h10);
        exp_q.push_back(32'hC0DE0010);
        issued_cnt++;
        base = req_seen;
        wait_req(base + 2, 200);
        pc_r = 32'h10;
        wait_done(300);
        fetch(32'h0,  32'h00500093, 0, 1);
        fetch(32'h1C, 32'hC0DE001C, 0, 1);

        // Reset during word 2 of a refill.
        @(posedge clk);
        #1 pc_r = 32'h20;
        exp_addr_q.push_back(32'h20);
        exp_addr_q.push_back(32'h24);
        exp_addr_q.push_back(32'h28);
        base = req_seen;
        wait_req(base + 3, 200);
        rst_n = 0;
        @(posedge clk);
        #1 rst_chk = 1;
        pc_r = 32'h0;
        @(negedge clk);
        #1 rst_chk = 0;
        rst_n = 1;
        fetch(32'h0,  32'h00500093, 1, 200);
        fetch(32'h20, 32'hC0DE0020, 1, 200);

        // Memory keeps a stale ready across the request gap.
        stale_mode = 1;
        fetch(32'h30, 32'hC0DE0030, 1, 200);
        stale_mode = 0;
        fetch(32'h34, 32'hC0DE0034, 0, 1);
        fetch(32'h38, 32'hC0DE0038, 0, 1);
        fetch(32'h3C, 32'hC0DE003C, 0, 1);

        repeat (3) @(negedge clk);
        #1 end_chk = 1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
